// File: rtl/arp_table_ctrl_if.sv
// ARP table controller bus: learn/lookup request ports, flush control and table RAM port.
// Latency: none; plain wires bundled for port connection.
// Backpressure: req/ack handshakes, requester holds req and operands until ack.
interface arp_table_ctrl_if;
    logic        lrn_req;
    logic [31:0] lrn_ip;
    logic [47:0] lrn_mac;
    logic        lrn_ack;

    logic        lk_req;
    logic [31:0] lk_ip;
    logic        lk_ack;
    logic        lk_done;
    logic        lk_hit;
    logic [47:0] lk_mac;

    logic        flush_req;
    logic        flush_busy;

    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [80:0] ram_wdata;
    logic        ram_re;
    logic [80:0] ram_rdata;

    // Controller side
    modport slave (
        input  lrn_req, lrn_ip, lrn_mac, lk_req, lk_ip, flush_req, ram_rdata,
        output lrn_ack, lk_ack, lk_done, lk_hit, lk_mac, flush_busy,
               ram_addr, ram_we, ram_wdata, ram_re
    );

    // Requester / RAM side
    modport master (
        output lrn_req, lrn_ip, lrn_mac, lk_req, lk_ip, flush_req, ram_rdata,
        input  lrn_ack, lk_ack, lk_done, lk_hit, lk_mac, flush_busy,
               ram_addr, ram_we, ram_wdata, ram_re
    );
endinterface

// File: rtl/arp_table_ctrl.sv
// ARP cache controller: arbitrates learn/lookup onto the 1024-entry table RAM, hashes IPs, runs flushes.
// Latency: lookup result 2 cycles after ack, learn write 1 cycle after ack, flush 1024 cycles.
// Backpressure: requests wait (no ack) while another op, a pending flush or a flush is in progress.

// CRC-16 (poly 0x1021, init 0xFFFF, MSB first) of the IP; low 10 bits index the table.
module arp_table_hash (
    input  logic [31:0] ip,
    output logic [9:0]  addr
);
    logic [15:0] crc;

    // Bit-serial CRC unrolled into combinational logic
    always_comb begin
        crc = 16'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            if (crc[15] ^ ip[i])
                crc = {crc[14:0], 1'b0} ^ 16'h1021;
            else
                crc = {crc[14:0], 1'b0};
        end
    end

    assign addr = crc[9:0];
endmodule

module arp_table_ctrl (
    input  logic              clk,
    input  logic              reset,
    arp_table_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, LK_RD, LK_CMP, LRN_WR, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [31:0] ip_q;
    logic [47:0] mac_q;
    logic        flush_pend;
    logic [9:0]  flush_cnt;
    logic        last_grant;   // 1: last grant went to learn, 0: to lookup
    logic        grant_lrn;
    logic        grant_lk;
    logic [9:0]  hash_addr;
    logic        rd_hit;

    // Hash always sees the latched IP so the address is stable for the whole operation
    arp_table_hash hash (
        .ip   (ip_q),
        .addr (hash_addr)
    );

    assign rd_hit         = bus.ram_rdata[80] & (bus.ram_rdata[79:48] == ip_q);
    assign bus.flush_busy = flush_pend | (state == FLUSH);

    // Grant arbitration in IDLE: pending flush blocks grants, ties alternate on last_grant
    always_comb begin
        grant_lrn = 1'b0;
        grant_lk  = 1'b0;
        if (!reset && state == IDLE && !flush_pend) begin
            if (bus.lrn_req && bus.lk_req) begin
                if (last_grant)
                    grant_lk  = 1'b1;
                else
                    grant_lrn = 1'b1;
            end else if (bus.lrn_req) begin
                grant_lrn = 1'b1;
            end else if (bus.lk_req) begin
                grant_lk  = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and state-decoded outputs; RAM port is idle (all zero) outside active states
    always_comb begin
        state_nxt     = state;
        bus.lrn_ack   = 1'b0;
        bus.lk_ack    = 1'b0;
        bus.lk_done   = 1'b0;
        bus.lk_hit    = 1'b0;
        bus.lk_mac    = 48'd0;
        bus.ram_addr  = 10'd0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = 81'd0;
        bus.ram_re    = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pend) begin
                    state_nxt = FLUSH;
                end else if (grant_lrn) begin
                    bus.lrn_ack = 1'b1;
                    state_nxt   = LRN_WR;
                end else if (grant_lk) begin
                    bus.lk_ack = 1'b1;
                    state_nxt  = LK_RD;
                end
            end
            LK_RD: begin
                bus.ram_re   = 1'b1;
                bus.ram_addr = hash_addr;
                state_nxt    = LK_CMP;
            end
            LK_CMP: begin
                bus.lk_done = 1'b1;
                bus.lk_hit  = rd_hit;
                bus.lk_mac  = rd_hit ? bus.ram_rdata[47:0] : 48'd0;
                state_nxt   = IDLE;
            end
            LRN_WR: begin
                // 0.0.0.0 is never stored; the slot keeps whatever it held
                bus.ram_addr  = hash_addr;
                bus.ram_we    = (ip_q != 32'd0);
                bus.ram_wdata = {1'b1, ip_q, mac_q};
                state_nxt     = IDLE;
            end
            FLUSH: begin
                bus.ram_addr = flush_cnt;
                bus.ram_we   = 1'b1;
                if (flush_cnt == 10'd1023)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request operand capture and round-robin memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip_q       <= 32'd0;
            mac_q      <= 48'd0;
            last_grant <= 1'b0;
        end else if (grant_lrn) begin
            ip_q       <= bus.lrn_ip;
            mac_q      <= bus.lrn_mac;
            last_grant <= 1'b1;
        end else if (grant_lk) begin
            ip_q       <= bus.lk_ip;
            last_grant <= 1'b0;
        end
    end

    // Flush pending flag: consumed on entry to FLUSH, requests during FLUSH are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flush_pend <= 1'b0;
        else if (state == IDLE && flush_pend)
            flush_pend <= 1'b0;
        else if (bus.flush_req && state != FLUSH)
            flush_pend <= 1'b1;
    end

    // Flush address counter; wraps to 0 after the last entry so the next flush starts clean
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flush_cnt <= 10'd0;
        else if (state == FLUSH)
            flush_cnt <= flush_cnt + 10'd1;
        else
            flush_cnt <= 10'd0;
    end
endmodule

// File: tb/tb_arp_table_ctrl.sv
// Bench for arp_table_ctrl: RAM model plus a table-level reference model driven by random traffic.
// Latency: checks ack->write 1 cycle, ack->done 2 cycles, flush 1024 writes.
// Backpressure: requests are held until acked; every wait is cycle-bounded.
module tb_arp_table_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arp_table_ctrl_if bus ();

    arp_table_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Table RAM model: synchronous write, registered read
    logic [80:0] mem [1024] = '{default: '0};
    always @(posedge clk) begin
        if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_re)
            bus.ram_rdata <= mem[bus.ram_addr];
    end

    // Reference view of the table, indexed by hashed address
    bit          mv   [1024];
    logic [31:0] mip  [1024];
    logic [47:0] mmac [1024];

    int n_chk  = 0;
    int n_fail = 0;
    logic [9:0] seen_addr;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC-16/CCITT-FALSE over the 32-bit IP, MSB first, as integer arithmetic
    function automatic logic [9:0] ref_hash(input logic [31:0] ip);
        int unsigned c;
        int unsigned top;
        c = 32'hFFFF;
        for (int i = 31; i >= 0; i--) begin
            top = ((c >> 15) ^ 32'(ip[i])) & 32'd1;
            c = (c << 1) & 32'hFFFF;
            if (top != 0)
                c = c ^ 32'h1021;
        end
        return c[9:0];
    endfunction

    function automatic logic [159:0] outs_all();
        return 160'({bus.lrn_ack, bus.lk_ack, bus.lk_done, bus.lk_hit, bus.lk_mac,
                     bus.flush_busy, bus.ram_addr, bus.ram_we, bus.ram_wdata, bus.ram_re});
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++)
            mv[i] = 1'b0;
    endtask

    task automatic model_learn(input logic [31:0] ip, input logic [47:0] mac);
        logic [9:0] h;
        h = ref_hash(ip);
        if (ip != 32'd0) begin
            mv[h]   = 1'b1;
            mip[h]  = ip;
            mmac[h] = mac;
        end
    endtask

    function automatic bit model_hit(input logic [31:0] ip);
        logic [9:0] h;
        h = ref_hash(ip);
        return mv[h] && (mip[h] == ip);
    endfunction

    task automatic do_learn(input logic [31:0] ip, input logic [47:0] mac);
        @(negedge clk);
        bus.lrn_req = 1'b1;
        bus.lrn_ip  = ip;
        bus.lrn_mac = mac;
        #1;
        for (int c = 0; c < 20 && !bus.lrn_ack; c++) begin
            @(negedge clk);
            #1;
        end
        check("lrn_ack", bus.lrn_ack, 1);
        if (!bus.lrn_ack) begin
            bus.lrn_req = 1'b0;
            return;
        end
        @(negedge clk);
        bus.lrn_req = 1'b0;
        #1;
        seen_addr = bus.ram_addr;
        check("lrn ram_we", bus.ram_we, (ip != 32'd0));
        check("lrn ram_addr", bus.ram_addr, ref_hash(ip));
        if (ip != 32'd0)
            check("lrn ram_wdata", bus.ram_wdata, {1'b1, ip, mac});
        model_learn(ip, mac);
    endtask

    task automatic do_lookup(input logic [31:0] ip);
        bit exp_hit;
        @(negedge clk);
        bus.lk_req = 1'b1;
        bus.lk_ip  = ip;
        #1;
        for (int c = 0; c < 20 && !bus.lk_ack; c++) begin
            @(negedge clk);
            #1;
        end
        check("lk_ack", bus.lk_ack, 1);
        if (!bus.lk_ack) begin
            bus.lk_req = 1'b0;
            return;
        end
        exp_hit = model_hit(ip);
        @(negedge clk);
        bus.lk_req = 1'b0;
        #1;
        check("lk ram_re", {bus.ram_re, bus.lk_done}, 2'b10);
        check("lk ram_addr", bus.ram_addr, ref_hash(ip));
        @(negedge clk);
        #1;
        check("lk_done", bus.lk_done, 1);
        check("lk_hit", bus.lk_hit, exp_hit);
        check("lk_mac", bus.lk_mac, exp_hit ? mmac[ref_hash(ip)] : 48'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ip_a, ip_b, ip_x, ip_z, ip_l;
        logic [47:0] mac_x, mac_l;
        logic [31:0] pool [8];
        int nw, bad, ackseen, acks, last_cyc;
        bit exp_lrn, found;

        reset         = 1'b1;
        bus.lrn_req   = 1'b0;
        bus.lrn_ip    = '0;
        bus.lrn_mac   = '0;
        bus.lk_req    = 1'b0;
        bus.lk_ip     = '0;
        bus.flush_req = 1'b0;
        model_clear();
        #1;
        check("reset outputs", outs_all(), 160'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Empty table miss, then learn + hit
        do_lookup(32'h0A000001);
        do_learn(32'hC0A8010A, 48'h001122334455);
        do_lookup(32'hC0A8010A);
        check("known mac", bus.lk_mac, 48'h001122334455);

        // Collision: two IPs sharing one slot
        ip_a = $urandom | 32'h1;
        ip_b = 32'd0;
        found = 1'b0;
        for (int k = 0; k < 200000 && !found; k++) begin
            ip_b = $urandom;
            if (ip_b != ip_a && ip_b != 32'd0 && ref_hash(ip_b) == ref_hash(ip_a))
                found = 1'b1;
        end
        check("collision search", found, 1);
        do_learn(ip_a, 48'hA1A2A3A4A5A6);
        begin
            logic [9:0] addr_a;
            addr_a = seen_addr;
            do_learn(ip_b, 48'hB1B2B3B4B5B6);
            check("collision addr", seen_addr, addr_a);
        end
        do_lookup(ip_a);
        check("collided ip misses", bus.lk_hit, 0);
        do_lookup(ip_b);
        check("newer ip hits", bus.lk_hit, 1);

        // Random mixed traffic against the reference table
        pool[0] = ip_a;
        pool[1] = ip_b;
        pool[2] = 32'hC0A8010A;
        pool[3] = 32'h0A000001;
        pool[4] = 32'd0;
        for (int i = 5; i < 8; i++)
            pool[i] = $urandom;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 1)
                do_learn(pool[$urandom_range(7, 0)], {16'h0, $urandom});
            else
                do_lookup(pool[$urandom_range(7, 0)]);
        end

        // Flush issued while a lookup is in LK_RD
        ip_x  = $urandom | 32'h100;
        mac_x = {16'hCAFE, $urandom};
        do_learn(ip_x, mac_x);
        @(negedge clk);
        bus.lk_req = 1'b1;
        bus.lk_ip  = ip_x;
        #1;
        for (int c = 0; c < 20 && !bus.lk_ack; c++) begin
            @(negedge clk);
            #1;
        end
        check("flush lk_ack", bus.lk_ack, 1);
        @(negedge clk);
        bus.lk_req    = 1'b0;
        bus.flush_req = 1'b1;
        #1;
        check("flush-cycle ram_re", bus.ram_re, 1);
        check("busy before pending", bus.flush_busy, 0);
        @(negedge clk);
        bus.flush_req = 1'b0;
        bus.lrn_req   = 1'b1;
        bus.lrn_ip    = 32'd0;
        bus.lrn_mac   = 48'h123456789ABC;
        #1;
        check("lookup completes", {bus.lk_done, bus.lk_hit}, 2'b11);
        check("lookup mac before flush", bus.lk_mac, mac_x);
        check("busy after req", bus.flush_busy, 1);
        nw = 0;
        bad = 0;
        ackseen = 0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            #1;
            if (!bus.flush_busy)
                break;
            if (bus.lrn_ack || bus.lk_ack)
                ackseen++;
            if (bus.ram_we) begin
                if (bus.ram_addr != nw[9:0] || bus.ram_wdata != 81'd0)
                    bad++;
                nw++;
            end else if (nw > 0) begin
                bad++;
            end
        end
        check("flush write count", nw, 1024);
        check("flush write pattern", bad, 0);
        check("acks during flush", ackseen, 0);
        check("busy falls", bus.flush_busy, 0);
        check("grant after flush", bus.lrn_ack, 1);
        model_clear();
        @(negedge clk);
        bus.lrn_req = 1'b0;
        #1;
        check("zero ip no write", bus.ram_we, 0);
        do_lookup(ip_x);
        check("post-flush miss", bus.lk_hit, 0);

        // Reset while in LRN_WR
        @(negedge clk);
        bus.lrn_req = 1'b1;
        bus.lrn_ip  = $urandom | 32'h1;
        bus.lrn_mac = 48'hDEADBEEF0001;
        #1;
        for (int c = 0; c < 20 && !bus.lrn_ack; c++) begin
            @(negedge clk);
            #1;
        end
        check("pre-reset lrn_ack", bus.lrn_ack, 1);
        @(negedge clk);
        bus.lrn_req = 1'b0;
        reset       = 1'b1;
        #1;
        check("reset in LRN_WR", outs_all(), 160'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Both requesters held: learn first after reset, then strict alternation
        ip_l  = $urandom | 32'h10;
        mac_l = {16'hBEEF, $urandom};
        bus.lrn_ip  = ip_l;
        bus.lrn_mac = mac_l;
        bus.lk_ip   = ip_l;
        acks     = 0;
        last_cyc = -1;
        exp_lrn  = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            bus.lrn_req = (acks < 6);
            bus.lk_req  = (acks < 6);
            #1;
            if (bus.lrn_ack || bus.lk_ack) begin
                check("rr order", {bus.lrn_ack, bus.lk_ack}, exp_lrn ? 2'b10 : 2'b01);
                if (last_cyc >= 0)
                    check("rr wait", ((cyc - last_cyc) <= 3), 1);
                if (bus.lrn_ack)
                    model_learn(ip_l, mac_l);
                exp_lrn  = !exp_lrn;
                last_cyc = cyc;
                acks++;
            end
            if (bus.lk_done) begin
                check("rr lk_hit", bus.lk_hit, model_hit(ip_l));
                check("rr lk_mac", bus.lk_mac, mac_l);
            end
        end
        check("rr ack count", acks, 6);

        // Reset in the middle of a flush
        @(negedge clk);
        bus.flush_req = 1'b1;
        @(negedge clk);
        bus.flush_req = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check("flush running", {bus.flush_busy, bus.ram_we}, 2'b11);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset mid-flush", outs_all(), 160'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("busy after reset", bus.flush_busy, 0);
        model_clear();
        ip_z = $urandom | 32'h1000;
        do_learn(ip_z, 48'h0A0B0C0D0E0F);
        do_lookup(ip_z);
        check("resume after reset", {bus.lk_hit, bus.lk_mac}, {1'b1, 48'h0A0B0C0D0E0F});

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
